// File: rtl/chk_pkg.sv
// Shared types and helpers for the channel activity checker.
package chk_pkg;

    typedef enum logic [1:0] {
        ANY_HIGH    = 2'd0,
        ONE_HOT     = 2'd1,
        AT_MOST_ONE = 2'd2
    } chk_mode_e;

    // Widest channel group the popcount helper accepts.
    localparam int unsigned MAX_CH = 64;

    // All-ones value of a W-bit counter, as an integer (W <= 31).
    function automatic int unsigned sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Counts bits that are definitely 1; X/Z bits contribute nothing.
    function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            if (v[i] === 1'b1) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear+inc gives 1.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/chan_activity_checker.sv
// Run-time rule checker over an N-channel signal group with miss tolerance,
// sticky error, saturating counters and first-failure capture.
module chan_activity_checker
    import chk_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter chk_mode_e   MODE     = ANY_HIGH,
    parameter int unsigned MAX_MISS = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  sig,
    input  logic             clr_err,
    output logic             viol,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] first_cyc,
    output logic [N_CH-1:0]  first_sig
);

    localparam int unsigned      RUN_W    = $clog2(MAX_MISS + 2);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] MISS_LIM = RUN_W'(MAX_MISS);

    int unsigned      pcnt;
    logic             sig_known;
    logic             rule_ok;
    logic             ok;
    logic             err_sample;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_eff;
    logic [RUN_W-1:0] run_inc;

    // Rule decode; a clear restarts the violation run before this sample counts.
    always_comb begin
        pcnt      = popcount(MAX_CH'(sig));
        sig_known = ((^sig) !== 1'bx);
        rule_ok   = 1'b0;
        unique case (MODE)
            ANY_HIGH:    rule_ok = (pcnt >= 1);
            ONE_HOT:     rule_ok = (pcnt == 1);
            AT_MOST_ONE: rule_ok = (pcnt <= 1);
            default:     rule_ok = 1'b0;
        endcase
        ok         = rule_ok && sig_known;
        run_eff    = clr_err ? '0 : run;
        run_inc    = (run_eff == RUN_MAX) ? RUN_MAX : run_eff + RUN_W'(1);
        err_sample = en && !ok && (run_eff >= MISS_LIM);
    end

    // Later assignments deliberately override the clear when an error lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            viol      <= 1'b0;
            err       <= 1'b0;
            run       <= '0;
            first_cyc <= '0;
            first_sig <= '0;
        end else begin
            viol <= en && !ok;
            if (clr_err) begin
                err       <= 1'b0;
                run       <= '0;
                first_cyc <= '0;
                first_sig <= '0;
            end
            if (en) begin
                run <= ok ? '0 : run_inc;
                if (err_sample) begin
                    err <= 1'b1;
                    if (!err || clr_err) begin
                        first_cyc <= cyc_cnt;
                        first_sig <= sig;
                    end
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_err),
        .inc   (err_sample),
        .count (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (en),
        .count (cyc_cnt)
    );

endmodule

// File: tb/tb_chan_activity_checker.sv
// Bench for chan_activity_checker: four differently parametrised instances
// share stimulus and are compared every cycle against a behavioural model.
module tb_chan_activity_checker;
    import chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr_err;
    logic [3:0] sig;

    always #5 clk = ~clk;

    // Instance parameters: A(N2,ANY,0,16) B(N4,ONE_HOT,0,16) C(N4,ANY,2,16) D(N4,AT_MOST_ONE,1,4)
    localparam int P_MODE [4] = '{0, 1, 0, 2};
    localparam int P_MM   [4] = '{0, 0, 2, 1};
    localparam int P_MAX  [4] = '{65535, 65535, 65535, 15};
    localparam int P_MASK [4] = '{3, 15, 15, 15};

    logic        a_viol, a_err, b_viol, b_err, c_viol, c_err, d_viol, d_err;
    logic [15:0] a_ec, a_cc, a_fc, b_ec, b_cc, b_fc, c_ec, c_cc, c_fc;
    logic [3:0]  d_ec, d_cc, d_fc;
    logic [1:0]  a_fs;
    logic [3:0]  b_fs, c_fs, d_fs;

    chan_activity_checker #(.N_CH(2), .MODE(ANY_HIGH), .MAX_MISS(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .en(en), .sig(sig[1:0]), .clr_err(clr_err),
        .viol(a_viol), .err(a_err), .err_cnt(a_ec), .cyc_cnt(a_cc),
        .first_cyc(a_fc), .first_sig(a_fs));
    chan_activity_checker #(.N_CH(4), .MODE(ONE_HOT), .MAX_MISS(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr_err(clr_err),
        .viol(b_viol), .err(b_err), .err_cnt(b_ec), .cyc_cnt(b_cc),
        .first_cyc(b_fc), .first_sig(b_fs));
    chan_activity_checker #(.N_CH(4), .MODE(ANY_HIGH), .MAX_MISS(2), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr_err(clr_err),
        .viol(c_viol), .err(c_err), .err_cnt(c_ec), .cyc_cnt(c_cc),
        .first_cyc(c_fc), .first_sig(c_fs));
    chan_activity_checker #(.N_CH(4), .MODE(AT_MOST_ONE), .MAX_MISS(1), .CNT_W(4)) u_d (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .clr_err(clr_err),
        .viol(d_viol), .err(d_err), .err_cnt(d_ec), .cyc_cnt(d_cc),
        .first_cyc(d_fc), .first_sig(d_fs));

    logic [15:0] o_viol [4];
    logic [15:0] o_err  [4];
    logic [15:0] o_ec   [4];
    logic [15:0] o_cc   [4];
    logic [15:0] o_fc   [4];
    logic [15:0] o_fs   [4];

    assign o_viol = '{16'(a_viol), 16'(b_viol), 16'(c_viol), 16'(d_viol)};
    assign o_err  = '{16'(a_err),  16'(b_err),  16'(c_err),  16'(d_err)};
    assign o_ec   = '{a_ec, b_ec, c_ec, 16'(d_ec)};
    assign o_cc   = '{a_cc, b_cc, c_cc, 16'(d_cc)};
    assign o_fc   = '{a_fc, b_fc, c_fc, 16'(d_fc)};
    assign o_fs   = '{16'(a_fs), 16'(b_fs), 16'(c_fs), 16'(d_fs)};

    // Reference model state (consecutive-violation count kept as an unbounded integer).
    int m_viol [4];
    int m_err  [4];
    int m_ec   [4];
    int m_cc   [4];
    int m_fc   [4];
    int m_fs   [4];
    int m_run  [4];

    int n_checks = 0;
    int n_err    = 0;

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int  s;
            int  p;
            bit  ok;
            bit  hit;
            int  old_cc;
            if (rst) begin
                m_viol[k] = 0; m_err[k] = 0; m_ec[k] = 0; m_cc[k] = 0;
                m_fc[k] = 0; m_fs[k] = 0; m_run[k] = 0;
            end else begin
                s = int'(sig) & P_MASK[k];
                p = $countones(s);
                case (P_MODE[k])
                    0:       ok = (p >= 1);
                    1:       ok = (p == 1);
                    default: ok = (p <= 1);
                endcase
                m_viol[k] = (en && !ok) ? 1 : 0;
                if (clr_err) begin
                    m_err[k] = 0; m_ec[k] = 0; m_fc[k] = 0; m_fs[k] = 0; m_run[k] = 0;
                end
                if (en) begin
                    hit    = !ok && (m_run[k] >= P_MM[k]);
                    old_cc = m_cc[k];
                    if (m_cc[k] < P_MAX[k]) m_cc[k] = m_cc[k] + 1;
                    m_run[k] = ok ? 0 : m_run[k] + 1;
                    if (hit) begin
                        if (m_err[k] == 0) begin
                            m_fc[k] = old_cc;
                            m_fs[k] = s;
                        end
                        m_err[k] = 1;
                        if (m_ec[k] < P_MAX[k]) m_ec[k] = m_ec[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk("viol",      k, o_viol[k], 16'(m_viol[k]));
            chk("err",       k, o_err[k],  16'(m_err[k]));
            chk("err_cnt",   k, o_ec[k],   16'(m_ec[k]));
            chk("cyc_cnt",   k, o_cc[k],   16'(m_cc[k]));
            chk("first_cyc", k, o_fc[k],   16'(m_fc[k]));
            chk("first_sig", k, o_fs[k],   16'(m_fs[k]));
        end
    endtask

    // Drive mid-cycle, advance one edge, update the model, sample 1 time unit later.
    task automatic tick(input logic r, input logic e, input logic c, input logic [3:0] s);
        rst = r; en = e; clr_err = c; sig = s;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr_err = 1'b0; sig = 4'b0;
        @(negedge clk);

        // Reset state
        tick(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) chk("rst_err_cnt", k, o_ec[k], 16'd0);

        // T1: first enabled sample violates any-high with no tolerance
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        chk("t1_viol", 0, o_viol[0], 16'd1);
        chk("t1_err", 0, o_err[0], 16'd1);
        chk("t1_err_cnt", 0, o_ec[0], 16'd1);
        chk("t1_first_cyc", 0, o_fc[0], 16'd0);
        chk("t1_first_sig", 0, o_fs[0], 16'd0);

        // T2: one-hot sequence with a single two-hot sample
        tick(1'b1, 1'b0, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0001);
        tick(1'b0, 1'b1, 1'b0, 4'b0010);
        tick(1'b0, 1'b1, 1'b0, 4'b0110);
        chk("t2_viol_hit", 1, o_viol[1], 16'd1);
        tick(1'b0, 1'b1, 1'b0, 4'b1000);
        chk("t2_viol_clear", 1, o_viol[1], 16'd0);
        chk("t2_err_cnt", 1, o_ec[1], 16'd1);
        chk("t2_first_cyc", 1, o_fc[1], 16'd2);
        chk("t2_first_sig", 1, o_fs[1], 16'h6);

        // T3: two misses tolerated, third consecutive miss is the error
        tick(1'b1, 1'b0, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0001);
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        chk("t3_no_err_yet", 2, o_err[2], 16'd0);
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        chk("t3_err", 2, o_err[2], 16'd1);
        chk("t3_err_cnt", 2, o_ec[2], 16'd1);
        chk("t3_first_cyc", 2, o_fc[2], 16'd5);

        // T4: enable low holds everything and suppresses viol
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 4'b0000);
        chk("t4_viol", 2, o_viol[2], 16'd0);
        chk("t4_cyc_hold", 2, o_cc[2], 16'd6);
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        chk("t4_resume_cyc", 2, o_cc[2], 16'd7);

        // T5: clear coinciding with an error sample, then a clean clear
        tick(1'b1, 1'b0, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0001);
        tick(1'b0, 1'b1, 1'b1, 4'b0000);
        chk("t5_err", 0, o_err[0], 16'd1);
        chk("t5_err_cnt", 0, o_ec[0], 16'd1);
        chk("t5_first_cyc", 0, o_fc[0], 16'd2);
        tick(1'b0, 1'b1, 1'b1, 4'b0001);
        chk("t5_clr_err", 0, o_err[0], 16'd0);
        chk("t5_clr_err_cnt", 0, o_ec[0], 16'd0);

        // T6: saturation of 4-bit counters, then reset mid-run
        tick(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 4'b0011);
        chk("t6_err_cnt_sat", 3, o_ec[3], 16'd15);
        chk("t6_cyc_cnt_sat", 3, o_cc[3], 16'd15);
        chk("t6_err_sticky", 3, o_err[3], 16'd1);
        tick(1'b1, 1'b1, 1'b0, 4'b0011);
        chk("t6_rst_err_cnt", 3, o_ec[3], 16'd0);
        chk("t6_rst_viol", 3, o_viol[3], 16'd0);
        tick(1'b0, 1'b1, 1'b0, 4'b0011);
        chk("t6_run_discarded", 3, o_err[3], 16'd0);

        // Randomised traffic with occasional reset, clear and idle cycles
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic       e;
            logic       c;
            logic [3:0] s;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       s = 4'b0000;
                1:       s = 4'(1 << $urandom_range(0, 3));
                default: s = 4'($urandom);
            endcase
            tick(r, e, c, s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
